wave_trigger_scan: RTL and testbench
====================================

Name: wave_trigger_scan

Overview:
- Downstream consumer of the ADC capture RAM on the read side (clk_system domain).
- On each frame request it scans the captured buffer for a rising crossing of the trigger level, then streams DISP_W decimated samples starting at the trigger point to the HDMI waveform renderer.
- It drives the RAM read address and absorbs the RAM's 1-cycle read latency.
- Output uses a valid/ready handshake.

Parameters:
- SAMPLING_NUM, 20000, captured buffer depth; addresses run 0..SAMPLING_NUM-1 and wrap.
- DISP_W, 640, samples streamed per frame (one per display column).
- SEARCH_LIMIT, 4000, maximum addresses examined for a trigger before free-running.
- HYST, 4, hysteresis margin in LSB (used only with the optional feature).

Ports:
- clk_system  in  1  system/display clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Frame_Start  in  1  single-cycle pulse requesting a new frame scan.
- Trigger_Gate  in  8  trigger level (unsigned ADC code).
- Decim  in  8  address step per output sample; 0 is treated as 1.
- Ram_Data  in  8  RAM read data, valid 1 cycle after Read_Addr.
- Read_Addr  out  18  RAM read address.
- Sample_Out  out  8  streamed sample.
- Sample_Valid  out  1  Sample_Out is valid.
- Sample_Ready  in  1  downstream accepts when Valid && Ready.
- Sample_Last  out  1  high with the DISP_W-th sample.
- Trig_Found  out  1  latched per frame: 1 = trigger located, 0 = free-run from address 0.
- Busy  out  1  high outside IDLE.

Behaviour:
- Reset is asynchronous and active-low. Reset values: state IDLE; Read_Addr=0; Sample_Out=0; Sample_Valid=0; Sample_Last=0; Trig_Found=0; Busy=0. Skid buffer is emptied. Reset mid-frame abandons the frame with no further output.
- IDLE:
  - Frame_Start goes to SEARCH.
  - Read_Addr=0; sample count cleared; prev-valid flag cleared.
- SEARCH:
  - Read_Addr increments by 1 each cycle, starting at 0.
  - Data returning 1 cycle later is compared as prev/cur pairs.
  - Trigger condition: prev < Trigger_Gate and cur >= Trigger_Gate.
  - The first pair (address 0) has no prev and cannot trigger.
  - On trigger at data address A: latch start=A, set Trig_Found=1, go to STREAM.
  - If SEARCH_LIMIT addresses are examined with no trigger: start=0, Trig_Found=0, go to STREAM.
  - Read requests issued in flight after the decision are discarded.
- STREAM:
  - Read_Addr = start + k*step, where step = max(Decim,1), for k=0..DISP_W-1.
  - Address wrap: if addr+step >= SAMPLING_NUM, the next address is addr+step-SAMPLING_NUM. Compute in 19 bits with no truncation.
  - Reads are issued only while the 2-entry skid buffer has space, counting reads in flight. No sample is lost or duplicated under any Ready pattern.
  - Sample_Out and Sample_Valid come from the skid buffer head. Sample_Valid stays high and Sample_Out stays stable until accepted.
  - Sample_Last is high with sample k=DISP_W-1.
  - Latency: first Sample_Valid no earlier than 2 cycles after entering STREAM.
  - After the last handshake, go to DONE.
- DONE: one cycle, then IDLE. Busy falls on entry to IDLE.
- Frame_Start while Busy=1 is ignored.
- Trig_Found holds its value until the next Frame_Start is accepted, then clears.
- Trigger_Gate and Decim are sampled on Frame_Start acceptance and held for the whole frame.

Optional Feature:
- Macro: WAVE_TRIG_HYST_EN.
- Defined: the trigger arms only after a sample <= Trigger_Gate-HYST (saturating at 0) has been seen. The armed condition then requires cur >= Trigger_Gate. Noise within the band does not retrigger. Arm state clears on Frame_Start.
- Undefined: plain prev/cur crossing as above; the HYST parameter is unused.

Decomposition:
- Shared package wave_pkg:
  - state enum (IDLE, SEARCH, STREAM, DONE)
  - ADDR_W=18 and DATA_W=8
  - the default SAMPLING_NUM constant shared with the capture side.
- One natural sub-module: wave_skid_buf, a 2-entry valid/ready skid buffer with count output, used for the RAM-latency absorption.

Test Plan:
- Ramp RAM (data=addr[7:0]), Gate=100, Decim=1, Ready=1 → trigger at address 100; Trig_Found=1; first sample=100; 640 samples, last=(739 mod 256)=227 with Sample_Last.
- Constant RAM=50, Gate=100 → no trigger after 4000 addresses; Trig_Found=0; stream starts at address 0; 640 samples all 50.
- Trigger at address 19900, Decim=1 → addresses 19900..19999 then 0..539; Read_Addr never reaches 20000; 640 samples.
- Ramp RAM, Decim=0 and Decim=3 → step 1 and step 3 respectively; sample k equals (start+k*step)[7:0].
- Random Ready (30% low) → exactly 640 handshakes; sequence identical to the Ready=1 run; Sample_Out stable while Valid && !Ready.
- Rst low at sample 200 → all outputs 0 immediately; a new Frame_Start after release runs a full 640-sample frame. A Frame_Start pulse during Busy produces no second frame.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform read-side scanner.
package wave_pkg;

  localparam int unsigned ADDR_W           = 18;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned SAMPLING_NUM_DEF = 20000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wave_state_e;

endpackage

// File: rtl/wave_skid_buf.sv
// Two-entry valid/ready buffer absorbing the capture RAM's one-cycle read latency.
module wave_skid_buf import wave_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             pop;

  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The producer never pushes into a full buffer, so no overflow guard is needed.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wave_trigger_scan.sv
// Scans the capture RAM for a rising trigger crossing, then streams DISP_W decimated samples.
// Optional hysteresis arming is enabled by defining WAVE_TRIG_HYST_EN.
module wave_trigger_scan import wave_pkg::*; #(
  parameter int unsigned SAMPLING_NUM = SAMPLING_NUM_DEF,
  parameter int unsigned DISP_W       = 640,
  parameter int unsigned SEARCH_LIMIT = 4000
`ifdef WAVE_TRIG_HYST_EN
  ,
  parameter int unsigned HYST         = 4
`endif
) (
  input  logic              clk_system,
  input  logic              Rst,
  input  logic              Frame_Start,
  input  logic [DATA_W-1:0] Trigger_Gate,
  input  logic [DATA_W-1:0] Decim,
  input  logic [DATA_W-1:0] Ram_Data,
  output logic [ADDR_W-1:0] Read_Addr,
  output logic [DATA_W-1:0] Sample_Out,
  output logic              Sample_Valid,
  input  logic              Sample_Ready,
  output logic              Sample_Last,
  output logic              Trig_Found,
  output logic              Busy
);

  localparam int unsigned CNT_W = $clog2(DISP_W + 1);
  localparam logic [ADDR_W:0]   SAMP_N      = (ADDR_W + 1)'(SAMPLING_NUM);
  localparam logic [ADDR_W-1:0] LAST_SEARCH = ADDR_W'(SEARCH_LIMIT - 1);
  localparam logic [CNT_W-1:0]  DISP_N      = CNT_W'(DISP_W);
  localparam logic [CNT_W-1:0]  DISP_LAST   = CNT_W'(DISP_W - 1);

  wave_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0] gate_q, gate_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic              trig_q, trig_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
`ifdef WAVE_TRIG_HYST_EN
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] gate_lo;
`endif

  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W:0]   addr_next;
  logic [2:0]        occupancy;
  logic              issue;
  logic              trig_hit;
  logic              skid_push;
  logic [DATA_W:0]   skid_head;
  logic [1:0]        skid_count;
  logic              pop;

  wave_skid_buf #(.WIDTH(DATA_W + 1)) u_skid (
    .clk_i   (clk_system),
    .rst_ni  (Rst),
    .push_i  (skid_push),
    .data_i  ({rd_last_q, Ram_Data}),
    .ready_i (Sample_Ready),
    .valid_o (Sample_Valid),
    .data_o  (skid_head),
    .count_o (skid_count)
  );

  assign pop         = Sample_Valid && Sample_Ready;
  assign Sample_Out  = skid_head[DATA_W-1:0];
  assign Sample_Last = Sample_Valid && skid_head[DATA_W];
  assign Read_Addr   = addr_q;
  assign Trig_Found  = trig_q;
  assign Busy        = (state_q != IDLE);

  // Wrapped next stream address, kept one bit wider so the sum never truncates.
  always_comb begin
    addr_sum  = {1'b0, addr_q} + {{(ADDR_W + 1 - DATA_W){1'b0}}, step_q};
    addr_next = (addr_sum >= SAMP_N) ? (addr_sum - SAMP_N) : addr_sum;
    occupancy = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, pop};
    issue     = (issue_cnt_q < DISP_N) && (occupancy < 3'd2);
`ifdef WAVE_TRIG_HYST_EN
    gate_lo   = (gate_q > DATA_W'(HYST)) ? (gate_q - DATA_W'(HYST)) : '0;
    trig_hit  = armed_q && (Ram_Data >= gate_q);
`else
    trig_hit  = prev_valid_q && (prev_q < gate_q) && (Ram_Data >= gate_q);
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_addr_d  = data_addr_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = rd_last_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    gate_d       = gate_q;
    step_d       = step_q;
    trig_d       = trig_q;
    issue_cnt_d  = issue_cnt_q;
    skid_push    = 1'b0;
`ifdef WAVE_TRIG_HYST_EN
    armed_d      = armed_q;
`endif

    unique case (state_q)
      IDLE: begin
        addr_d       = '0;
        issue_cnt_d  = '0;
        prev_valid_d = 1'b0;
        if (Frame_Start) begin
          state_d = SEARCH;
          gate_d  = Trigger_Gate;
          step_d  = (Decim == '0) ? DATA_W'(1) : Decim;
          trig_d  = 1'b0;
`ifdef WAVE_TRIG_HYST_EN
          armed_d = 1'b0;
`endif
        end
      end

      SEARCH: begin
        addr_d      = addr_q + ADDR_W'(1);
        data_addr_d = addr_q;
        rd_pend_d   = 1'b1;
        if (rd_pend_q) begin
          prev_d       = Ram_Data;
          prev_valid_d = 1'b1;
`ifdef WAVE_TRIG_HYST_EN
          if (Ram_Data <= gate_lo) armed_d = 1'b1;
`endif
          // The read issued this cycle is dropped by clearing the pending flag.
          if (trig_hit) begin
            state_d   = STREAM;
            addr_d    = data_addr_q;
            trig_d    = 1'b1;
            rd_pend_d = 1'b0;
          end else if (data_addr_q == LAST_SEARCH) begin
            state_d   = STREAM;
            addr_d    = '0;
            trig_d    = 1'b0;
            rd_pend_d = 1'b0;
          end
        end
      end

      STREAM: begin
        skid_push = rd_pend_q;
        rd_pend_d = issue;
        if (issue) begin
          addr_d      = addr_next[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          rd_last_d   = (issue_cnt_q == DISP_LAST);
        end
        if (pop && skid_head[DATA_W]) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_system or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_addr_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      gate_q       <= '0;
      step_q       <= DATA_W'(1);
      trig_q       <= 1'b0;
      issue_cnt_q  <= '0;
`ifdef WAVE_TRIG_HYST_EN
      armed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_addr_q  <= data_addr_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      gate_q       <= gate_d;
      step_q       <= step_d;
      trig_q       <= trig_d;
      issue_cnt_q  <= issue_cnt_d;
`ifdef WAVE_TRIG_HYST_EN
      armed_q      <= armed_d;
`endif
    end
  end

endmodule

// File: tb/tb_wave_trigger_scan.sv
// Self-checking bench for wave_trigger_scan: RAM model, reference trigger search and sample stream.
module tb_wave_trigger_scan;

  localparam int SN     = 20000;
  localparam int DISP_W = 640;
  localparam int LIMIT  = 4000;
  localparam int HYST   = 4;

  logic        clk_system;
  logic        Rst;
  logic        Frame_Start;
  logic [7:0]  Trigger_Gate;
  logic [7:0]  Decim;
  logic [7:0]  Ram_Data;
  logic [17:0] Read_Addr;
  logic [7:0]  Sample_Out;
  logic        Sample_Valid;
  logic        Sample_Ready;
  logic        Sample_Last;
  logic        Trig_Found;
  logic        Busy;

  logic [7:0]  mem [SN];
  int          vectors;
  int          miscompares;
  int          exp_start;
  int          exp_step;
  bit          exp_found;
  int          first_seen;
  int          last_seen;

  wave_trigger_scan dut (
    .clk_system   (clk_system),
    .Rst          (Rst),
    .Frame_Start  (Frame_Start),
    .Trigger_Gate (Trigger_Gate),
    .Decim        (Decim),
    .Ram_Data     (Ram_Data),
    .Read_Addr    (Read_Addr),
    .Sample_Out   (Sample_Out),
    .Sample_Valid (Sample_Valid),
    .Sample_Ready (Sample_Ready),
    .Sample_Last  (Sample_Last),
    .Trig_Found   (Trig_Found),
    .Busy         (Busy)
  );

  initial clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  always @(posedge clk_system) begin
    Ram_Data <= (int'(Read_Addr) < SN) ? mem[Read_Addr] : 8'h00;
  end

  task automatic fill_ramp();
    for (int i = 0; i < SN; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < SN; i++) mem[i] = v;
  endtask

  task automatic fill_step(input int edge_at);
    for (int i = 0; i < SN; i++) mem[i] = (i >= edge_at) ? 8'd200 : 8'd0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < SN; i++) mem[i] = 8'($urandom);
  endtask

  task automatic model_frame(input logic [7:0] gate, input logic [7:0] decim);
    exp_step  = (decim == 8'd0) ? 1 : int'(decim);
    exp_start = 0;
    exp_found = 1'b0;
`ifdef WAVE_TRIG_HYST_EN
    begin
      bit armed;
      int lo;
      armed = 1'b0;
      lo = (int'(gate) > HYST) ? int'(gate) - HYST : 0;
      for (int a = 0; a < LIMIT; a++) begin
        if (armed && mem[a] >= gate) begin
          exp_start = a;
          exp_found = 1'b1;
          break;
        end
        if (int'(mem[a]) <= lo) armed = 1'b1;
      end
    end
`else
    for (int a = 1; a < LIMIT; a++) begin
      if (mem[a-1] < gate && mem[a] >= gate) begin
        exp_start = a;
        exp_found = 1'b1;
        break;
      end
    end
`endif
  endtask

  // Runs one frame; abort_at > 0 returns right after that many handshakes, poke re-pulses Frame_Start mid-frame.
  task automatic run_frame(input logic [7:0] gate, input logic [7:0] decim, input int low_pct,
                           input int abort_at, input bit poke, input string name);
    int k, cycles;
    bit held, addr_bad;
    logic [7:0] held_val, expv;
    model_frame(gate, decim);
    k = 0; cycles = 0; held = 1'b0; addr_bad = 1'b0; held_val = '0;
    Trigger_Gate = gate;
    Decim        = decim;
    Sample_Ready = ($urandom_range(99) >= low_pct);
    Frame_Start  = 1'b1;
    @(posedge clk_system); #1;
    Frame_Start  = 1'b0;
    Trigger_Gate = ~gate;
    Decim        = decim + 8'd1;
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s busy_on_start: got %b expected 1", name, Busy);
    end
    while (k < DISP_W && cycles < 20000) begin
      if (abort_at > 0 && k == abort_at) return;
      @(negedge clk_system);
      cycles++;
      if (poke && cycles == 5) Frame_Start = 1'b1;
      if (poke && cycles == 6) Frame_Start = 1'b0;
      if (int'(Read_Addr) >= SN) addr_bad = 1'b1;
      if (held) begin
        vectors++;
        if (Sample_Valid !== 1'b1 || Sample_Out !== held_val) begin
          miscompares++;
          $display("[TB] FAIL %s hold_stable k=%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                   name, k, Sample_Valid, Sample_Out, held_val);
        end
      end
      held     = Sample_Valid && !Sample_Ready;
      held_val = Sample_Out;
      if (Sample_Valid && Sample_Ready) begin
        expv = mem[(exp_start + k * exp_step) % SN];
        vectors++;
        if (Sample_Out !== expv) begin
          miscompares++;
          $display("[TB] FAIL %s sample k=%0d: got %0d expected %0d", name, k, Sample_Out, expv);
        end
        vectors++;
        if (Sample_Last !== (k == DISP_W - 1)) begin
          miscompares++;
          $display("[TB] FAIL %s last_flag k=%0d: got %b expected %b", name, k, Sample_Last, (k == DISP_W - 1));
        end
        if (k == 0) first_seen = int'(Sample_Out);
        last_seen = int'(Sample_Out);
        k++;
      end
      @(posedge clk_system); #1;
      Sample_Ready = ($urandom_range(99) >= low_pct);
    end
    vectors++;
    if (k != DISP_W) begin
      miscompares++;
      $display("[TB] FAIL %s handshake_count: got %0d expected %0d", name, k, DISP_W);
    end
    cycles = 0;
    while (Busy && cycles < 10) begin
      @(posedge clk_system); #1;
      cycles++;
    end
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s busy_end: got %b expected 0", name, Busy);
    end
    vectors++;
    if (Trig_Found !== exp_found) begin
      miscompares++;
      $display("[TB] FAIL %s trig_found: got %b expected %b", name, Trig_Found, exp_found);
    end
    vectors++;
    if (addr_bad) begin
      miscompares++;
      $display("[TB] FAIL %s read_addr_range: got out-of-range expected < %0d", name, SN);
    end
    vectors++;
    if (Sample_Valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s valid_after_done: got %b expected 0", name, Sample_Valid);
    end
    if (poke) begin
      bit rebusy;
      rebusy = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk_system); #1;
        if (Busy) rebusy = 1'b1;
      end
      vectors++;
      if (rebusy) begin
        miscompares++;
        $display("[TB] FAIL %s second_frame: got busy expected idle", name);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    vectors++;
    if (Read_Addr !== '0 || Sample_Out !== '0 || Sample_Valid !== 1'b0 ||
        Sample_Last !== 1'b0 || Trig_Found !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s outputs: got addr=%0d out=%0d v=%b l=%b t=%b b=%b expected all 0",
               name, Read_Addr, Sample_Out, Sample_Valid, Sample_Last, Trig_Found, Busy);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    repeat (3) @(posedge clk_system);
    #1;
    check_zero_outputs("reset");
    Rst = 1'b1;
    @(posedge clk_system); #1;
    check_zero_outputs("after_release");
  endtask

  task automatic test_ramp();
    fill_ramp();
    run_frame(8'd100, 8'd1, 0, 0, 1'b0, "ramp");
    vectors++;
    if (first_seen != 100) begin
      miscompares++;
      $display("[TB] FAIL ramp first_sample: got %0d expected 100", first_seen);
    end
    vectors++;
    if (last_seen != 227) begin
      miscompares++;
      $display("[TB] FAIL ramp last_sample: got %0d expected 227", last_seen);
    end
    vectors++;
    if (Trig_Found !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ramp trig_const: got %b expected 1", Trig_Found);
    end
  endtask

  task automatic test_no_trigger();
    fill_const(8'd50);
    run_frame(8'd100, 8'd1, 0, 0, 1'b0, "const50");
    vectors++;
    if (Trig_Found !== 1'b0 || last_seen != 50) begin
      miscompares++;
      $display("[TB] FAIL const50 freerun: got trig=%b last=%0d expected trig=0 last=50", Trig_Found, last_seen);
    end
  endtask

  task automatic test_search_boundary();
    fill_step(LIMIT - 1);
    run_frame(8'd100, 8'd255, 0, 0, 1'b0, "edge_last_addr");
    fill_step(LIMIT);
    run_frame(8'd100, 8'd255, 0, 0, 1'b0, "edge_past_limit");
  endtask

  task automatic test_decim();
    fill_ramp();
    run_frame(8'd100, 8'd0, 0, 0, 1'b0, "decim0");
    run_frame(8'd100, 8'd3, 20, 0, 1'b0, "decim3");
  endtask

  task automatic test_random_ready();
    fill_ramp();
    run_frame(8'd100, 8'd1, 30, 0, 1'b0, "ready30");
    for (int f = 0; f < 2; f++) begin
      fill_random();
      run_frame(8'($urandom), 8'($urandom_range(0, 4)), 30, 0, 1'b0, "random_frame");
    end
    run_frame(8'($urandom), 8'd255, 30, 0, 1'b0, "random_wrap");
  endtask

  task automatic test_reset_midframe();
    fill_ramp();
    run_frame(8'd100, 8'd1, 0, 200, 1'b0, "abort");
    Rst = 1'b0;
    #1;
    check_zero_outputs("midframe_reset");
    @(posedge clk_system); #1;
    Rst = 1'b1;
    @(posedge clk_system); #1;
    run_frame(8'd100, 8'd1, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    run_frame(8'd60, 8'd2, 10, 0, 1'b1, "busy_poke");
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    first_seen   = -1;
    last_seen    = -1;
    Rst          = 1'b0;
    Frame_Start  = 1'b0;
    Trigger_Gate = '0;
    Decim        = '0;
    Sample_Ready = 1'b0;
    fill_const(8'd0);
    test_reset();
    test_ramp();
    test_no_trigger();
    test_search_boundary();
    test_decim();
    test_random_ready();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
